// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its bench.
package ifetch_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [5:0]  OP_J       = 6'b000010;
    localparam logic [5:0]  OP_JAL     = 6'b000011;
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/instruction_fetch_next_pc_calc.sv
// Next-PC selection: jr > j/jal > taken beq > sequential. Purely combinational.
module next_pc_calc
    import ifetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        pcwr_i,
    input  logic        pcsrc_i,
    input  logic        is_jump_i,
    input  logic        branch_taken_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] imm26_i,
    input  logic [29:0] jr_word_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o
);

    logic [31:0] br_off;

    assign pc_plus4_o = pc_i + 32'(WORD_BYTES);
    assign br_off     = {{14{imm16_i[15]}}, imm16_i, 2'b00};

    always_comb begin
        next_pc_o = pc_plus4_o;
        if (pcwr_i) begin
            next_pc_o = {jr_word_i, 2'b00};
        end else if (pcsrc_i && is_jump_i) begin
            next_pc_o = {pc_plus4_o[31:28], imm26_i, 2'b00};
        end else if (pcsrc_i && branch_taken_i) begin
            next_pc_o = pc_plus4_o + br_off;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, imem req/ready handshake, instruction register for the decoder.
// Optional IFETCH_MISALIGN_TRAP_EN adds misalign_trap_o and restarts fetch on a misaligned jr.
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    output logic [31:0] instruction_o,
    output logic        instr_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        pcsrc_i,
    input  logic        is_jump_i,
    input  logic        branch_taken_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] imm26_i,
    input  logic        pcwr_i,
    input  logic [31:0] jr_target_i
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap_o
`endif
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] next_pc;

    next_pc_calc u_next_pc (
        .pc_i           (pc_q),
        .pcwr_i         (pcwr_i),
        .pcsrc_i        (pcsrc_i),
        .is_jump_i      (is_jump_i),
        .branch_taken_i (branch_taken_i),
        .imm16_i        (imm16_i),
        .imm26_i        (imm26_i),
        .jr_word_i      (jr_target_i[31:2]),
        .pc_plus4_o     (pc_plus4_o),
        .next_pc_o      (next_pc)
    );

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic trap_q, trap_d;
    logic misalign;

    assign misalign        = pcwr_i && (jr_target_i[1:0] != 2'b00);
    assign misalign_trap_o = trap_q;
`else
    // jr low bits are masked off entirely when the trap is not built in
    logic unused_jr_lsb;
    assign unused_jr_lsb = ^jr_target_i[1:0];
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
        trap_d  = 1'b0;
`endif
        case (state_q)
            RESET: state_d = REQ;
            REQ, WAIT: begin
                if (imem_ready_i) begin
                    instr_d = imem_rdata_i;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                if (!stall_i) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = REQ;
`ifdef IFETCH_MISALIGN_TRAP_EN
                    if (misalign) begin
                        pc_d   = RESET_PC;
                        trap_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = RESET;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RESET;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
            trap_q  <= trap_d;
`endif
        end
    end

    assign imem_req_o    = (state_q == REQ) || (state_q == WAIT);
    assign imem_addr_o   = pc_q;
    assign instruction_o = valid_q ? instr_q : NOP_INSTR;
    assign instr_valid_o = valid_q;
    assign pc_o          = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory responder feeds a scoreboard checked when instr_valid rises.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b1;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pcsrc = 1'b0;
    logic        is_jump = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] imm16 = 16'h0;
    logic [25:0] imm26 = 26'h0;
    logic        pcwr = 1'b0;
    logic [31:0] jr_target = 32'h0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int checks = 0;
    int errors = 0;
    int mem_lat = 0;
    int mem_cnt = 0;
    bit force_ready = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;

    typedef struct {
        logic        wr, src, jmp, bt;
        logic [15:0] i16;
        logic [25:0] i26;
        logic [31:0] jt;
        logic [31:0] exp;
    } redir_t;

    instruction_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_ready_i   (imem_ready),
        .imem_rdata_i   (imem_rdata),
        .stall_i        (stall),
        .instruction_o  (instruction),
        .instr_valid_o  (instr_valid),
        .pc_o           (pc),
        .pc_plus4_o     (pc_plus4),
        .pcsrc_i        (pcsrc),
        .is_jump_i      (is_jump),
        .branch_taken_i (branch_taken),
        .imm16_i        (imm16),
        .imm26_i        (imm26),
        .pcwr_i         (pcwr),
        .jr_target_i    (jr_target)
`ifdef IFETCH_MISALIGN_TRAP_EN
        ,
        .misalign_trap_o(misalign_trap)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    // memory: answers mem_lat cycles after req appears, pushing the expected word
    always @(negedge clk) begin
        if (force_ready) begin
            imem_ready = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            mem_cnt    = 0;
        end else if (!rst_n) begin
            imem_ready = 1'b0;
            mem_cnt    = 0;
        end else if (imem_req === 1'b1 && !imem_ready) begin
            if (mem_cnt >= mem_lat) begin
                imem_ready = 1'b1;
                imem_rdata = mem_word(imem_addr);
                exp_q.push_back('{imem_addr, mem_word(imem_addr)});
                mem_cnt    = 0;
            end else begin
                mem_cnt++;
            end
        end else begin
            imem_ready = 1'b0;
            mem_cnt    = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (instr_valid === 1'b1 && !prev_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty: instr_valid at pc=%h, required no fetch", pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (instruction !== mon_e.instr || pc !== mon_e.pc || pc_plus4 !== mon_e.pc + 32'd4) begin
                        errors++;
                        $display("FAIL sb_fetch: instr=%h pc=%h pc4=%h, required instr=%h pc=%h pc4=%h",
                                 instruction, pc, pc_plus4, mon_e.instr, mon_e.pc, mon_e.pc + 32'd4);
                    end
                end
            end
            prev_valid = instr_valid;
        end
    end

    task automatic wait_valid(input string tag);
        int n = 0;
        while (instr_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (instr_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: instr_valid=%b, required 1", tag, instr_valid);
        end
    endtask

    task automatic consume(input logic wr, input logic src, input logic jmp, input logic bt,
                           input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] jt);
        pcwr = wr; pcsrc = src; is_jump = jmp; branch_taken = bt;
        imm16 = i16; imm26 = i26; jr_target = jt;
        stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        pcwr = 1'b0; pcsrc = 1'b0; is_jump = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC || instr_valid !== 1'b0 ||
            instruction !== NOP || pc !== RST_PC) begin
            errors++;
            $display("FAIL reset: req=%b addr=%h valid=%b instr=%h pc=%h, required 0 %h 0 %h %h",
                     imem_req, imem_addr, instr_valid, instruction, pc, RST_PC, NOP, RST_PC);
        end
`ifdef IFETCH_MISALIGN_TRAP_EN
        checks++;
        if (misalign_trap !== 1'b0) begin
            errors++;
            $display("FAIL reset_trap: misalign_trap=%b, required 0", misalign_trap);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero_wait();
        int n;
        mem_lat = 0;
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n = 0;
            while (imem_req !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
                errors++;
                $display("FAIL zero_wait_addr[%0d]: req=%b addr=%h, required 1 %h", i, imem_req, imem_addr, 32'(4 * i));
            end
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL zero_wait_valid[%0d]: instr_valid=%b, required 1", i, instr_valid);
            end
            if (i == 2) stall = 1'b1;
        end
    endtask

    task automatic test_wait_states();
        mem_lat = 3;
        consume(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'hC || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_req[%0d]: req=%b addr=%h valid=%b, required 1 0000000c 0",
                         k, imem_req, imem_addr, instr_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instruction !== mem_word(32'hC)) begin
            errors++;
            $display("FAIL wait_load: valid=%b instr=%h, required 1 %h", instr_valid, instruction, mem_word(32'hC));
        end
        mem_lat = 0;
    endtask

    task automatic test_stall();
        consume(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL stall_pre_addr: req=%b addr=%h, required 1 00000010", imem_req, imem_addr);
        end
        wait_valid("stall_fetch");
        // redirects presented while stalled must be ignored
        pcwr = 1'b1; pcsrc = 1'b1; is_jump = 1'b1; jr_target = 32'h200;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || pc !== 32'h10 || imem_req !== 1'b0 || instruction !== mem_word(32'h10)) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h req=%b instr=%h, required 1 00000010 0 %h",
                         k, instr_valid, pc, imem_req, instruction, mem_word(32'h10));
            end
        end
        consume(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
            errors++;
            $display("FAIL stall_next_addr: req=%b addr=%h, required 1 00000014", imem_req, imem_addr);
        end
        wait_valid("stall_next");
    endtask

    task automatic test_branch();
        redir_t tbl [6];
        tbl = '{
            '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h20, 32'h20},
            '{1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE, 26'h0, 32'h0,  32'h1C},
            '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h20, 32'h20},
            '{1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0, 32'h0,  32'h24},
            '{1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 26'h0, 32'h0,  32'h24},
            '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 26'h0, 32'h0,  32'h28}
        };
        for (int i = 0; i < 6; i++) begin
            consume(tbl[i].wr, tbl[i].src, tbl[i].jmp, tbl[i].bt, tbl[i].i16, tbl[i].i26, tbl[i].jt);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== tbl[i].exp) begin
                errors++;
                $display("FAIL branch[%0d]: req=%b addr=%h, required 1 %h", i, imem_req, imem_addr, tbl[i].exp);
            end
            wait_valid("branch");
        end
    endtask

    task automatic test_jump();
        redir_t tbl [5];
        tbl = '{
            '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0,       32'h4000_0000, 32'h4000_0000},
            '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 26'h0000010, 32'h0,         32'h4000_0040},
            '{1'b1, 1'b1, 1'b1, 1'b1, 16'h4, 26'h0000020, 32'h100,       32'h100},
            '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0,       32'hFFFF_FFFC, 32'hFFFF_FFFC},
            '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0,       32'h0,         32'h0}
        };
        for (int i = 0; i < 5; i++) begin
            consume(tbl[i].wr, tbl[i].src, tbl[i].jmp, tbl[i].bt, tbl[i].i16, tbl[i].i26, tbl[i].jt);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== tbl[i].exp) begin
                errors++;
                $display("FAIL jump[%0d]: req=%b addr=%h, required 1 %h", i, imem_req, imem_addr, tbl[i].exp);
            end
            wait_valid("jump");
        end
    endtask

    task automatic test_jr_misalign();
`ifdef IFETCH_MISALIGN_TRAP_EN
        consume(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h102);
        checks++;
        if (misalign_trap !== 1'b1 || imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL misalign_trap: trap=%b req=%b addr=%h, required 1 1 %h", misalign_trap, imem_req, imem_addr, RST_PC);
        end
        @(negedge clk);
        checks++;
        if (misalign_trap !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse: trap=%b, required 0", misalign_trap);
        end
`else
        consume(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h103);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL jr_mask: req=%b addr=%h, required 1 00000100", imem_req, imem_addr);
        end
`endif
        wait_valid("misalign");
    endtask

    task automatic test_reset_mid();
        mem_lat = 10;
        consume(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC || pc !== RST_PC || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: req=%b addr=%h pc=%h valid=%b, required 0 %h %h 0",
                     imem_req, imem_addr, pc, instr_valid, RST_PC, RST_PC);
        end
        force_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_ignored: valid=%b, required 0", instr_valid);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        force_ready = 1'b0;
        mem_lat = 0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_restart: req=%b addr=%h valid=%b, required 1 %h 0", imem_req, imem_addr, instr_valid, RST_PC);
        end
        wait_valid("reset_restart");
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d entries, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_branch();
        test_jump();
        test_jr_misalign();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

endmodule
